// File: rtl/register_file.sv
// register_file: XLEN x NREGS RISC-V integer register file, x0 hardwired to zero,
// combinational reads, synchronous writes. Define REGFILE_BYPASS_EN for write-through bypass.
module register_file #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            rd_we,
  output logic [15:0]     wr_count
);

  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic [XLEN-1:0] w_view [0:NREGS-1];
  logic [15:0]     r_wr_count;
  logic            w_wr_en;
  logic            w_byp1;
  logic            w_byp2;

  assign w_wr_en  = rd_we && (rd_addr != {AW{1'b0}});
  assign wr_count = r_wr_count;

`ifdef REGFILE_BYPASS_EN
  assign w_byp1 = w_wr_en && (rs1_addr == rd_addr);
  assign w_byp2 = w_wr_en && (rs2_addr == rd_addr);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  // Storage and commit counter; x0 has no flop behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_count <= 16'd0;
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (w_wr_en) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      for (int i = 1; i < NREGS; i++) begin
        if (w_wr_en && (rd_addr == AW'(i))) begin
          r_regs[i] <= rd_data;
        end
      end
    end
  end

  // Flat read view with a constant zero at index 0 so the address mux is full.
  always_comb begin
    w_view[0] = {XLEN{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      w_view[i] = r_regs[i];
    end
  end

  // Read ports: forced to zero during reset, otherwise bypass or stored value.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    rs2_data = {XLEN{1'b0}};
    if (reset) begin
      rs1_data = {XLEN{1'b0}};
      rs2_data = {XLEN{1'b0}};
    end else begin
      rs1_data = w_byp1 ? rd_data : w_view[rs1_addr];
      rs2_data = w_byp2 ? rd_data : w_view[rs2_addr];
    end
  end

endmodule
